bist_ctrl: RTL and testbench
============================

Name: bist_ctrl

Overview:
- Self-test sequencer for the 5-bit LFSR pattern generator / 4-bit SISR signature compactor pair.
- On a start pulse it:
  - seeds the internal LFSR and clears the internal SISR;
  - streams N_PATTERNS patterns to an external circuit under test and compacts the returned response bit each cycle;
  - compares the final signature with a golden value and reports done/pass.
- Sits between a test-mode master (CPU or top-level FSM) and any combinational block under test, such as the multiple-of-8 checker.

Parameters:
- N_PATTERNS, 31, number of patterns applied per run (1..31; 31 = full LFSR period).
- SEED, 5'b11111, LFSR load value at run start; must be nonzero.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE.
- abort  input  1  cancels a run in progress (SEED or RUN states).
- golden  input  4  expected signature, sampled in CMP.
- resp_in  input  1  response bit from circuit under test; must be combinationally derived from pat in the same cycle.
- pat  output  5  current LFSR pattern (q[4:0]).
- pat_valid  output  1  high exactly in RUN cycles.
- busy  output  1  high in SEED, RUN, CMP.
- done  output  1  one-cycle pulse, high in DONE state.
- pass  output  1  registered compare result, held until next start or reset.
- signature  output  4  registered final SISR value, held until next start or reset.

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, lfsr=0, sisr=0, cnt=0, pass=0, signature=0. All outputs 0 afterwards, including pat.
- LFSR step, applied in RUN only: q0<=q4, q1<=q0, q2<=q1^q4, q3<=q2, q4<=q3.
- SISR step, applied in RUN only, i=resp_in: s0<=s3^i, s1<=s3^s0, s2<=s1, s3<=s2.
- Pattern counter cnt is a 5-bit register; it is never compared beyond N_PATTERNS-1, so no wrap occurs.
- FSM transitions:
  - IDLE: start=1 → SEED, pass<=0, signature<=0. Otherwise stay in IDLE.
  - SEED (1 cycle): lfsr<=SEED, sisr<=0, cnt<=0, → RUN. abort=1 → IDLE, with no register loads.
  - RUN:
    - pat_valid=1, pat=lfsr.
    - Each edge: SISR step with resp_in, LFSR step, cnt<=cnt+1.
    - When cnt==N_PATTERNS-1 at the edge → CMP. That edge's step is still applied, so exactly N_PATTERNS responses are compacted.
    - abort=1 → IDLE, with no SISR/LFSR update on that edge; pass stays 0, done is never pulsed.
  - CMP (1 cycle): signature<=sisr, pass<=(sisr==golden), → DONE. abort is ignored.
  - DONE (1 cycle): done=1, → IDLE. A start during DONE is ignored.
- Timing: start sampled at edge E → SEED after E; RUN spans edges E+2..E+N_PATTERNS+1; done is high in the cycle after edge E+N_PATTERNS+2. Total latency is N_PATTERNS+3 cycles from start to done.
- start while busy or in DONE: ignored, with no restart.
- abort and start in the same IDLE cycle: start wins; abort only has effect in SEED/RUN.
- rst has priority over abort and start in every state.
- First pattern presented is SEED itself (11111); second is 11011; third is 10011.

Test Plan:
- Reset mid-RUN: rst=1 for 1 cycle during RUN → next cycle IDLE, busy=0, pat=0, pass=0, signature=0, no done pulse.
- Default run with resp_in tied 0, golden=0000: start pulse → pat sequence 11111, 11011, 10011, …; pat_valid high for exactly 31 cycles; done at cycle 34 after start; signature=0000, pass=1.
- N_PATTERNS=3, resp_in tied 1, golden=0111: SISR goes 0001, 0011, 0111 → signature=0111, pass=1. Repeat with golden=0110 → pass=0, signature=0111.
- N_PATTERNS=5, resp_in tied 1: signature=1100 (0001, 0011, 0111, 1111, 1100); check done is a single-cycle pulse and pass/signature hold until the next start.
- Abort at the 10th RUN cycle → IDLE next cycle, no done pulse, pass=0. Then start again → full run completes with the correct signature, proving SEED re-initialises the LFSR and SISR.
- start pulses held during RUN/CMP/DONE → no restart; cnt is unaffected; exactly one done per accepted start.
- Integration: resp_in = (pat[2:0]==0) driven by the checker. Compare the signature against a bench reference model of the LFSR and SISR equations above. Both golden=model value → pass=1 and golden=model^1 → pass=0.

Source files
------------

// File: rtl/bist_ctrl.sv
// bist_ctrl: sequences one self-test run of a 5-bit LFSR pattern source and a
// 4-bit SISR response compactor, then compares the signature with a golden value.
module bist_ctrl #(
  parameter int         N_PATTERNS = 31,
  parameter logic [4:0] SEED       = 5'b11111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] golden,
  input  logic       resp_in,
  output logic [4:0] pat,
  output logic       pat_valid,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] signature
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEED = 3'd1,
    S_RUN  = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(N_PATTERNS - 1);

  state_t     state_r;
  logic [4:0] lfsr_r;
  logic [3:0] sisr_r;
  logic [4:0] cnt_r;
  logic       pat_valid_r;
  logic       busy_r;
  logic       done_r;
  logic       pass_r;
  logic [3:0] signature_r;

  function automatic logic [4:0] lfsr_step(input logic [4:0] q);
    lfsr_step = {q[3], q[2], q[1] ^ q[4], q[0], q[4]};
  endfunction

  function automatic logic [3:0] sisr_step(input logic [3:0] s, input logic i);
    sisr_step = {s[2], s[1], s[3] ^ s[0], s[3] ^ i};
  endfunction

  // Run sequencer; status flags are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      lfsr_r      <= 5'd0;
      sisr_r      <= 4'd0;
      cnt_r       <= 5'd0;
      pat_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      signature_r <= 4'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r     <= S_SEED;
            busy_r      <= 1'b1;
            pass_r      <= 1'b0;
            signature_r <= 4'd0;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_SEED: begin
          if (abort) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else begin
            lfsr_r      <= SEED;
            sisr_r      <= 4'd0;
            cnt_r       <= 5'd0;
            pat_valid_r <= 1'b1;
            state_r     <= S_RUN;
          end
        end
        S_RUN: begin
          // An aborted edge leaves the LFSR and SISR untouched.
          if (abort) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            pat_valid_r <= 1'b0;
          end else begin
            sisr_r <= sisr_step(sisr_r, resp_in);
            lfsr_r <= lfsr_step(lfsr_r);
            cnt_r  <= cnt_r + 5'd1;
            if (cnt_r == LAST_CNT) begin
              state_r     <= S_CMP;
              pat_valid_r <= 1'b0;
            end else begin
              state_r <= S_RUN;
            end
          end
        end
        S_CMP: begin
          signature_r <= sisr_r;
          pass_r      <= (sisr_r == golden);
          busy_r      <= 1'b0;
          done_r      <= 1'b1;
          state_r     <= S_DONE;
        end
        S_DONE: begin
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r     <= S_IDLE;
          pat_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign pat       = lfsr_r;
  assign pat_valid = pat_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign signature = signature_r;

endmodule

// File: tb/tb_bist_ctrl.sv
// tb_bist_ctrl: three bist_ctrl instances (31, 3 and 5 patterns) checked every
// cycle against a run-position model, plus directed literal expectations.
module tb_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_v   [3];
  logic       abort_v   [3];
  logic [3:0] golden_v  [3];
  logic       resp_v    [3];
  logic [4:0] pat_v     [3];
  logic       pv_v      [3];
  logic       busy_v    [3];
  logic       done_v    [3];
  logic       pass_v    [3];
  logic [3:0] sig_v     [3];
  int         rmode     [3];
  logic [4:0] rmask     [3];

  // model: pos -1 idle, 0 seed, 1..N pattern index, N+1 compare, N+2 done
  int         pos       [3];
  logic [4:0] mpat      [3];
  logic [3:0] msisr     [3];
  logic [3:0] msig      [3];
  logic       mpass     [3];
  int         ndone     [3];

  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  function automatic int np_of(input int k);
    case (k)
      0:       return 31;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  // rotate-left with feedback tap into bit 2
  function automatic logic [4:0] lfsr_next(input logic [4:0] q);
    return {q[3:0], q[4]} ^ {2'b00, q[4], 2'b00};
  endfunction

  function automatic logic [3:0] sisr_next(input logic [3:0] s, input logic i);
    return {s[2:0], s[3]} ^ {2'b00, s[3], i};
  endfunction

  function automatic logic resp_f(input int mode, input logic [4:0] mask, input logic [4:0] p);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (p[2:0] == 3'b000);
      default: return ^(p & mask);
    endcase
  endfunction

  function automatic logic [3:0] ref_sig(input int n, input int mode, input logic [4:0] mask);
    logic [4:0] p;
    logic [3:0] s;
    p = 5'b11111;
    s = 4'b0000;
    for (int j = 0; j < n; j++) begin
      s = sisr_next(s, resp_f(mode, mask, p));
      p = lfsr_next(p);
    end
    return s;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_resp
    assign resp_v[g] = resp_f(rmode[g], rmask[g], pat_v[g]);
  end

  bist_ctrl #(.N_PATTERNS(31), .SEED(5'b11111)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .golden(golden_v[0]),
    .resp_in(resp_v[0]), .pat(pat_v[0]), .pat_valid(pv_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .pass(pass_v[0]), .signature(sig_v[0]));

  bist_ctrl #(.N_PATTERNS(3), .SEED(5'b11111)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .golden(golden_v[1]),
    .resp_in(resp_v[1]), .pat(pat_v[1]), .pat_valid(pv_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .pass(pass_v[1]), .signature(sig_v[1]));

  bist_ctrl #(.N_PATTERNS(5), .SEED(5'b11111)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]), .golden(golden_v[2]),
    .resp_in(resp_v[2]), .pat(pat_v[2]), .pat_valid(pv_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .pass(pass_v[2]), .signature(sig_v[2]));

  // reference model advance on each rising edge
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        pos[k]   <= -1;
        mpat[k]  <= 5'd0;
        msisr[k] <= 4'd0;
        msig[k]  <= 4'd0;
        mpass[k] <= 1'b0;
      end else if (pos[k] == -1) begin
        if (start_v[k]) begin
          pos[k]   <= 0;
          mpass[k] <= 1'b0;
          msig[k]  <= 4'd0;
        end
      end else if (pos[k] == 0) begin
        if (abort_v[k]) pos[k] <= -1;
        else begin
          mpat[k]  <= 5'b11111;
          msisr[k] <= 4'd0;
          pos[k]   <= 1;
        end
      end else if (pos[k] <= np_of(k)) begin
        if (abort_v[k]) pos[k] <= -1;
        else begin
          msisr[k] <= sisr_next(msisr[k], resp_f(rmode[k], rmask[k], mpat[k]));
          mpat[k]  <= lfsr_next(mpat[k]);
          pos[k]   <= pos[k] + 1;
        end
      end else if (pos[k] == np_of(k) + 1) begin
        msig[k]  <= msisr[k];
        mpass[k] <= (msisr[k] == golden_v[k]);
        pos[k]   <= pos[k] + 1;
      end else begin
        pos[k] <= -1;
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s[%0d]: got %0h, expected %0h", nm, k, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // issue one start pulse and follow the run until done (bounded)
  task automatic run_watch(input int k, output int lat, output int pvn,
                           output logic [4:0] p1, output logic [4:0] p2, output logic [4:0] p3);
    lat = -1; pvn = 0; p1 = 5'd0; p2 = 5'd0; p3 = 5'd0;
    start_v[k] = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (c == 1) start_v[k] = 1'b0;
      if (pv_v[k]) pvn++;
      if (c == 2) p1 = pat_v[k];
      if (c == 3) p2 = pat_v[k];
      if (c == 4) p3 = pat_v[k];
      if (done_v[k]) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout[%0d]: got no done, expected done within 100 cycles", k);
    end
  endtask

  int         lat, pvn, d0;
  logic [4:0] p1, p2, p3;
  logic [3:0] gref;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; abort_v[k] = 1'b0; golden_v[k] = 4'd0;
      rmode[k] = 0; rmask[k] = 5'd0; ndone[k] = 0;
    end

    // per-cycle comparison against the model
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          for (int k = 0; k < 3; k++) begin
            chk("pat", k, 32'(pat_v[k]), 32'(mpat[k]));
            chk("pat_valid", k, 32'(pv_v[k]), 32'(pos[k] >= 1 && pos[k] <= np_of(k)));
            chk("busy", k, 32'(busy_v[k]), 32'(pos[k] >= 0 && pos[k] <= np_of(k) + 1));
            chk("done", k, 32'(done_v[k]), 32'(pos[k] == np_of(k) + 2));
            chk("pass", k, 32'(pass_v[k]), 32'(mpass[k]));
            chk("signature", k, 32'(sig_v[k]), 32'(msig[k]));
            if (done_v[k]) ndone[k]++;
          end
        end
      end
    join_none

    repeat (3) tick();
    chk_en = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_pat", k, 32'(pat_v[k]), 32'h0);
      chk("rst_busy", k, 32'(busy_v[k]), 32'h0);
      chk("rst_pass", k, 32'(pass_v[k]), 32'h0);
      chk("rst_sig", k, 32'(sig_v[k]), 32'h0);
    end

    // default 31-pattern run, response tied low
    tick();
    run_watch(0, lat, pvn, p1, p2, p3);
    chk("lat31", 0, 32'(lat), 32'd34);
    chk("pv_count31", 0, 32'(pvn), 32'd31);
    chk("pat_first", 0, 32'(p1), 32'h1F);
    chk("pat_second", 0, 32'(p2), 32'h1B);
    chk("pat_third", 0, 32'(p3), 32'h13);
    tick();
    chk("sig31_tie0", 0, 32'(sig_v[0]), 32'h0);
    chk("pass31_tie0", 0, 32'(pass_v[0]), 32'h1);

    // three patterns, response tied high
    rmode[1] = 1; golden_v[1] = 4'b0111;
    run_watch(1, lat, pvn, p1, p2, p3);
    chk("lat3", 1, 32'(lat), 32'd6);
    tick();
    chk("sig3", 1, 32'(sig_v[1]), 32'h7);
    chk("pass3", 1, 32'(pass_v[1]), 32'h1);
    golden_v[1] = 4'b0110;
    run_watch(1, lat, pvn, p1, p2, p3);
    tick();
    chk("sig3_bad", 1, 32'(sig_v[1]), 32'h7);
    chk("pass3_bad", 1, 32'(pass_v[1]), 32'h0);

    // five patterns, response tied high; done is a single pulse and results hold
    rmode[2] = 1; golden_v[2] = 4'b1100;
    run_watch(2, lat, pvn, p1, p2, p3);
    chk("lat5", 2, 32'(lat), 32'd8);
    tick();
    chk("done_pulse", 2, 32'(done_v[2]), 32'h0);
    chk("sig5", 2, 32'(sig_v[2]), 32'hC);
    repeat (5) tick();
    chk("sig5_hold", 2, 32'(sig_v[2]), 32'hC);
    chk("pass5_hold", 2, 32'(pass_v[2]), 32'h1);

    // reset in the middle of a run
    start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
    repeat (6) tick();
    d0 = ndone[0];
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_busy", 0, 32'(busy_v[0]), 32'h0);
    chk("midrst_pat", 0, 32'(pat_v[0]), 32'h0);
    chk("midrst_pv", 0, 32'(pv_v[0]), 32'h0);
    chk("midrst_pass", 0, 32'(pass_v[0]), 32'h0);
    chk("midrst_sig", 0, 32'(sig_v[0]), 32'h0);
    repeat (40) tick();
    chk("midrst_no_done", 0, 32'(ndone[0]), 32'(d0));

    // abort at the 10th RUN cycle, then a full rerun with the checker response
    rmode[0] = 2; gref = ref_sig(31, 2, 5'd0); golden_v[0] = gref;
    start_v[0] = 1'b1; pvn = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      start_v[0] = 1'b0;
      if (pv_v[0]) pvn++;
      if (pvn == 10) begin
        abort_v[0] = 1'b1;
        break;
      end
    end
    d0 = ndone[0];
    tick(); abort_v[0] = 1'b0;
    chk("abort_busy", 0, 32'(busy_v[0]), 32'h0);
    chk("abort_pv", 0, 32'(pv_v[0]), 32'h0);
    chk("abort_pass", 0, 32'(pass_v[0]), 32'h0);
    repeat (40) tick();
    chk("abort_no_done", 0, 32'(ndone[0]), 32'(d0));
    run_watch(0, lat, pvn, p1, p2, p3);
    tick();
    chk("rerun_lat", 0, 32'(lat), 32'd34);
    chk("rerun_sig", 0, 32'(sig_v[0]), 32'(gref));
    chk("rerun_pass", 0, 32'(pass_v[0]), 32'h1);
    golden_v[0] = gref ^ 4'b0001;
    run_watch(0, lat, pvn, p1, p2, p3);
    tick();
    chk("integ_pass_bad", 0, 32'(pass_v[0]), 32'h0);
    chk("integ_sig", 0, 32'(sig_v[0]), 32'(gref));

    // start held through RUN/CMP/DONE must not restart the run
    golden_v[1] = 4'b0111;
    start_v[1] = 1'b1; lat = -1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (done_v[1]) begin
        lat = c;
        start_v[1] = 1'b0;
        break;
      end
    end
    start_v[1] = 1'b0;
    chk("held_lat", 1, 32'(lat), 32'd6);
    tick();
    d0 = ndone[1];
    repeat (15) tick();
    chk("held_one_done", 1, 32'(ndone[1]), 32'(d0));
    chk("held_pass", 1, 32'(pass_v[1]), 32'h1);

    // randomized runs: response functions, goldens, start spam, aborts, resets
    for (int it = 0; it < 60; it++) begin
      int k;
      k = $urandom_range(0, 2);
      rmode[k] = $urandom_range(0, 3);
      rmask[k] = 5'($urandom);
      if ($urandom_range(0, 1) == 1) golden_v[k] = ref_sig(np_of(k), rmode[k], rmask[k]);
      else golden_v[k] = 4'($urandom);
      start_v[k] = 1'b1;
      for (int c = 0; c < np_of(k) + 8; c++) begin
        tick();
        start_v[k] = ($urandom_range(0, 5) == 0);
        abort_v[k] = ($urandom_range(0, 29) == 0);
        rst        = ($urandom_range(0, 199) == 0);
      end
      start_v[k] = 1'b0; abort_v[k] = 1'b0; rst = 1'b0;
      for (int c = 0; c < 60; c++) begin
        tick();
        if (pos[k] == -1) break;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
